// File: rtl/timer_pkg.sv
// Shared types and BCD helpers for the MM:SS kitchen-timer core.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_t;

  localparam int unsigned DIGIT_W      = 4;
  localparam int unsigned DIGIT_MAX    = 9;
  localparam int unsigned SEC_TENS_MAX = 5;
  localparam int unsigned MIN_TENS_MAX = 9;

  // Digits packed as {min tens, min ones, sec tens, sec ones}
  localparam logic [4*DIGIT_W-1:0] TERM_DN = 16'h0000;
  localparam logic [4*DIGIT_W-1:0] TERM_UP = 16'h9959;

  function automatic logic preset_valid(input logic [7:0] min_bcd, input logic [7:0] sec_bcd);
    return (min_bcd[7:4] <= 4'(MIN_TENS_MAX)) && (min_bcd[3:0] <= 4'(DIGIT_MAX)) &&
           (sec_bcd[7:4] <= 4'(SEC_TENS_MAX)) && (sec_bcd[3:0] <= 4'(DIGIT_MAX));
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One modulo-(LIMIT+1) BCD digit; o_cy_c flags a borrow (down) or carry (up) on this step.
module bcd_digit
  import timer_pkg::*;
#(
  parameter int unsigned LIMIT = 9
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_en,
  input  logic               i_dir,
  input  logic               i_load,
  input  logic [DIGIT_W-1:0] i_load_val,
  output logic [DIGIT_W-1:0] o_digit,
  output logic               o_cy_c
);

  localparam logic [DIGIT_W-1:0] LIM = DIGIT_W'(LIMIT);

  logic [DIGIT_W-1:0] r_digit;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_digit <= '0;
    end else if (i_load) begin
      r_digit <= i_load_val;
    end else if (i_en) begin
      if (i_dir) r_digit <= (r_digit == LIM) ? '0 : r_digit + DIGIT_W'(1);
      else       r_digit <= (r_digit == '0) ? LIM : r_digit - DIGIT_W'(1);
    end
  end

  assign o_digit = r_digit;
  assign o_cy_c  = i_en && (i_dir ? (r_digit == LIM) : (r_digit == '0));

endmodule

// File: rtl/bcd_timer_core.sv
// MM:SS BCD countdown/stopwatch core: prescaler, control FSM, preset validation, digit cascade.
module bcd_timer_core
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter bit          WRAP     = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_load,
  input  logic [7:0] i_preset_min,
  input  logic [7:0] i_preset_sec,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic       i_up_mode,
  input  logic       i_ack,
  output logic [3:0] o_bin0,
  output logic [3:0] o_bin1,
  output logic [3:0] o_bin2,
  output logic [3:0] o_bin3,
  output logic       o_running,
  output logic       o_done,
  output logic       o_alarm,
  output logic       o_load_err
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_t        r_state;
  logic          r_dir;
  logic [PW-1:0] r_presc;
  logic          r_done, r_load_err, r_running, r_alarm;

  state_t        w_state_nxt;
  logic          w_dir_nxt;
  logic [PW-1:0] w_presc_nxt;
  logic          w_done_nxt, w_load_err_nxt, w_dig_load, w_step;

  logic [DIGIT_W-1:0]   w_d0, w_d1, w_d2, w_d3;
  logic                 w_cy0, w_cy1, w_cy2, w_cy3;
  logic [4*DIGIT_W-1:0] w_digits;
  logic                 w_tick, w_term_next, w_start_blk;

  assign w_digits    = {w_d3, w_d2, w_d1, w_d0};
  assign w_tick      = (r_state == RUN) && (r_presc == PRESC_LAST);
  // One step away from the terminal value in the current direction
  assign w_term_next = r_dir ? (w_digits == 16'h9958) : (w_digits == 16'h0001);
  assign w_start_blk = !WRAP && (i_up_mode ? (w_digits == TERM_UP) : (w_digits == TERM_DN));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_dir      <= 1'b0;
      r_presc    <= '0;
      r_done     <= 1'b0;
      r_load_err <= 1'b0;
      r_running  <= 1'b0;
      r_alarm    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_dir      <= w_dir_nxt;
      r_presc    <= w_presc_nxt;
      r_done     <= w_done_nxt;
      r_load_err <= w_load_err_nxt;
      r_running  <= (w_state_nxt == RUN);
      r_alarm    <= (w_state_nxt == ALARM);
    end
  end

  // Commands that are not legal in the current state fall through to lower priorities
  always_comb begin
    w_state_nxt    = r_state;
    w_dir_nxt      = r_dir;
    w_presc_nxt    = r_presc;
    w_done_nxt     = 1'b0;
    w_load_err_nxt = 1'b0;
    w_dig_load     = 1'b0;
    w_step         = 1'b0;
    if (i_load && (r_state != RUN)) begin
      if (preset_valid(i_preset_min, i_preset_sec)) begin
        w_dig_load  = 1'b1;
        w_state_nxt = IDLE;
      end else begin
        w_load_err_nxt = 1'b1;
      end
    end else if (i_stop && (r_state == RUN)) begin
      w_state_nxt = PAUSE;
    end else if (i_start && ((r_state == IDLE) || (r_state == PAUSE))) begin
      if (!w_start_blk) begin
        w_state_nxt = RUN;
        w_dir_nxt   = i_up_mode;
        w_presc_nxt = '0;
      end
    end else if (i_ack && (r_state == ALARM)) begin
      w_state_nxt = IDLE;
    end else if (r_state == RUN) begin
      if (w_tick) begin
        w_step      = 1'b1;
        w_presc_nxt = '0;
        if (!WRAP && w_term_next) begin
          w_state_nxt = ALARM;
          w_done_nxt  = 1'b1;
        end
      end else begin
        w_presc_nxt = r_presc + PW'(1);
      end
    end
  end

  bcd_digit #(.LIMIT(DIGIT_MAX)) u_sec_ones (
    .i_clk(i_clk), .i_reset(i_reset), .i_en(w_step), .i_dir(r_dir), .i_load(w_dig_load),
    .i_load_val(i_preset_sec[3:0]), .o_digit(w_d0), .o_cy_c(w_cy0)
  );
  bcd_digit #(.LIMIT(SEC_TENS_MAX)) u_sec_tens (
    .i_clk(i_clk), .i_reset(i_reset), .i_en(w_cy0), .i_dir(r_dir), .i_load(w_dig_load),
    .i_load_val(i_preset_sec[7:4]), .o_digit(w_d1), .o_cy_c(w_cy1)
  );
  bcd_digit #(.LIMIT(DIGIT_MAX)) u_min_ones (
    .i_clk(i_clk), .i_reset(i_reset), .i_en(w_cy1), .i_dir(r_dir), .i_load(w_dig_load),
    .i_load_val(i_preset_min[3:0]), .o_digit(w_d2), .o_cy_c(w_cy2)
  );
  // Top carry is unused: wrap-around at 99:59 / 00:00 falls out of the cascade
  bcd_digit #(.LIMIT(MIN_TENS_MAX)) u_min_tens (
    .i_clk(i_clk), .i_reset(i_reset), .i_en(w_cy2), .i_dir(r_dir), .i_load(w_dig_load),
    .i_load_val(i_preset_min[7:4]), .o_digit(w_d3), .o_cy_c(w_cy3)
  );

  logic w_unused;
  assign w_unused = w_cy3;

  assign o_bin0     = w_d0;
  assign o_bin1     = w_d1;
  assign o_bin2     = w_d2;
  assign o_bin3     = w_d3;
  assign o_running  = r_running;
  assign o_done     = r_done;
  assign o_alarm    = r_alarm;
  assign o_load_err = r_load_err;

endmodule

// File: tb/tb_bcd_timer_core.sv
// Bench for bcd_timer_core: WRAP=0 and WRAP=1 instances share stimulus, checked against a seconds-count model.
module tb_bcd_timer_core;

  localparam int TD = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_ALARM = 3;

  typedef struct {
    int st;
    int t;      // total seconds, 0..5999
    int presc;
    bit dir;
    bit done;
    bit lerr;
  } mdl_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1, load = 1'b0, start = 1'b0, stop = 1'b0, up = 1'b0, ack = 1'b0;
  logic [7:0] pmin = 8'h00, psec = 8'h00;

  logic [3:0] a0, a1, a2, a3, b0, b1, b2, b3;
  logic       a_run, a_done, a_alarm, a_lerr, b_run, b_done, b_alarm, b_lerr;
  logic [15:0] a_dig, b_dig;
  assign a_dig = {a3, a2, a1, a0};
  assign b_dig = {b3, b2, b1, b0};

  int   n_chk = 0, n_fail = 0;
  bit   chk_en = 1'b0;
  mdl_t m0, m1;

  bcd_timer_core #(.TICK_DIV(TD), .WRAP(1'b0)) u0 (
    .i_clk(clk), .i_reset(reset), .i_load(load), .i_preset_min(pmin), .i_preset_sec(psec),
    .i_start(start), .i_stop(stop), .i_up_mode(up), .i_ack(ack),
    .o_bin0(a0), .o_bin1(a1), .o_bin2(a2), .o_bin3(a3),
    .o_running(a_run), .o_done(a_done), .o_alarm(a_alarm), .o_load_err(a_lerr)
  );

  bcd_timer_core #(.TICK_DIV(TD), .WRAP(1'b1)) u1 (
    .i_clk(clk), .i_reset(reset), .i_load(load), .i_preset_min(pmin), .i_preset_sec(psec),
    .i_start(start), .i_stop(stop), .i_up_mode(up), .i_ack(ack),
    .o_bin0(b0), .o_bin1(b1), .o_bin2(b2), .o_bin3(b3),
    .o_running(b_run), .o_done(b_done), .o_alarm(b_alarm), .o_load_err(b_lerr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int t);
    int m, s;
    m = t / 60;
    s = t % 60;
    return {16'h0, 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic mdl_t step_model(input mdl_t m, input bit wrap, input bit rst, input bit ld,
                                      input logic [7:0] pm, input logic [7:0] ps, input bit sta,
                                      input bit sto, input bit u, input bit ak);
    mdl_t n;
    int   term;
    bit   ok;
    n = m;
    n.done = 1'b0;
    n.lerr = 1'b0;
    if (rst) begin
      n.st = M_IDLE; n.t = 0; n.presc = 0; n.dir = 1'b0;
      return n;
    end
    if (ld && m.st != M_RUN) begin
      ok = (int'(pm[7:4]) <= 9) && (int'(pm[3:0]) <= 9) && (int'(ps[7:4]) <= 5) && (int'(ps[3:0]) <= 9);
      if (ok) begin
        n.t  = (int'(pm[7:4]) * 10 + int'(pm[3:0])) * 60 + int'(ps[7:4]) * 10 + int'(ps[3:0]);
        n.st = M_IDLE;
      end else n.lerr = 1'b1;
    end else if (sto && m.st == M_RUN) begin
      n.st = M_PAUSE;
    end else if (sta && (m.st == M_IDLE || m.st == M_PAUSE)) begin
      if (wrap || !((!u && m.t == 0) || (u && m.t == 5999))) begin
        n.st = M_RUN; n.dir = u; n.presc = 0;
      end
    end else if (ak && m.st == M_ALARM) begin
      n.st = M_IDLE;
    end else if (m.st == M_RUN) begin
      if (m.presc == TD - 1) begin
        n.presc = 0;
        n.t     = m.dir ? (m.t + 1) % 6000 : (m.t + 5999) % 6000;
        term    = m.dir ? 5999 : 0;
        if (!wrap && n.t == term) begin
          n.st = M_ALARM; n.done = 1'b1;
        end
      end else n.presc = m.presc + 1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m0 = step_model(m0, 1'b0, reset, load, pmin, psec, start, stop, up, ack);
    m1 = step_model(m1, 1'b1, reset, load, pmin, psec, start, stop, up, ack);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("u0 digits", 32'(a_dig), to_bcd(m0.t));
      chk("u0 running", 32'(a_run), 32'(m0.st == M_RUN));
      chk("u0 alarm", 32'(a_alarm), 32'(m0.st == M_ALARM));
      chk("u0 done", 32'(a_done), 32'(m0.done));
      chk("u0 load_err", 32'(a_lerr), 32'(m0.lerr));
      chk("u1 digits", 32'(b_dig), to_bcd(m1.t));
      chk("u1 running", 32'(b_run), 32'(m1.st == M_RUN));
      chk("u1 alarm", 32'(b_alarm), 32'(m1.st == M_ALARM));
      chk("u1 done", 32'(b_done), 32'(m1.done));
      chk("u1 load_err", 32'(b_lerr), 32'(m1.lerr));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] mn, input logic [7:0] sc);
    load = 1'b1; pmin = mn; psec = sc;
    cyc(1);
    load = 1'b0;
  endtask

  task automatic pulse_start(input bit u);
    start = 1'b1; up = u;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
  endtask

  function automatic logic [7:0] rnd_bcd(input int tens_max);
    if ($urandom_range(0, 9) == 0) return 8'($urandom_range(0, 255));
    return {4'($urandom_range(0, tens_max)), 4'($urandom_range(0, 9))};
  endfunction

  initial begin
    m0 = '{default: 0};
    m1 = '{default: 0};
    cyc(2);
    reset  = 1'b0;
    chk_en = 1'b1;
    chk("reset digits", 32'(a_dig), 32'h0000);
    chk("reset running", 32'(a_run), 32'h0);

    // Countdown from 01:00 with first step TICK_DIV cycles after start
    do_load(8'h01, 8'h00);
    chk("load 01:00", 32'(a_dig), 32'h0100);
    pulse_start(1'b0);
    chk("running after start", 32'(a_run), 32'h1);
    cyc(4);
    chk("first step 00:59", 32'(a_dig), 32'h0059);
    cyc(4);
    chk("second step 00:58", 32'(a_dig), 32'h0058);

    // Pause holds digits; restart re-arms the prescaler
    pulse_stop();
    chk("paused running", 32'(a_run), 32'h0);
    cyc(3);
    chk("paused digits", 32'(a_dig), 32'h0058);
    pulse_start(1'b0);
    cyc(3);
    chk("no early step", 32'(a_dig), 32'h0058);
    cyc(1);
    chk("step after restart", 32'(a_dig), 32'h0057);
    cyc(3);
    pulse_stop();
    chk("stop beats tick", 32'(a_dig), 32'h0057);

    // Countdown to alarm, and WRAP=1 passing through 00:00
    do_load(8'h00, 8'h02);
    pulse_start(1'b0);
    cyc(7);
    chk("pre-terminal digits", 32'(a_dig), 32'h0001);
    chk("done low before", 32'(a_done), 32'h0);
    cyc(1);
    chk("terminal digits", 32'(a_dig), 32'h0000);
    chk("done pulse", 32'(a_done), 32'h1);
    chk("alarm set", 32'(a_alarm), 32'h1);
    chk("wrap still running", 32'(b_run), 32'h1);
    cyc(1);
    chk("done one cycle", 32'(a_done), 32'h0);
    chk("alarm held", 32'(a_alarm), 32'h1);
    cyc(3);
    chk("wrap 99:59", 32'(b_dig), 32'h9959);
    chk("wrap no done", 32'(b_done), 32'h0);
    pulse_start(1'b0);
    chk("start ignored in alarm", 32'(a_alarm), 32'h1);
    pulse_ack();
    chk("ack clears alarm", 32'(a_alarm), 32'h0);
    chk("ack keeps digits", 32'(a_dig), 32'h0000);
    pulse_stop();

    do_load(8'h00, 8'h01);
    pulse_start(1'b0);
    cyc(4);
    chk("wrap tick1 00:00", 32'(b_dig), 32'h0000);
    cyc(4);
    chk("wrap tick2 99:59", 32'(b_dig), 32'h9959);
    chk("wrap running", 32'(b_run), 32'h1);
    pulse_ack();
    pulse_stop();

    // Rejected presets
    do_load(8'h00, 8'h60);
    chk("bad sec load_err", 32'(a_lerr), 32'h1);
    chk("bad sec digits", 32'(a_dig), 32'h0000);
    cyc(1);
    chk("load_err one cycle", 32'(a_lerr), 32'h0);
    do_load(8'h0A, 8'h00);
    chk("bad min load_err", 32'(b_lerr), 32'h1);
    chk("bad min digits", 32'(b_dig), 32'h9959);

    // Up mode carries and up-terminal alarm
    do_load(8'h00, 8'h58);
    pulse_start(1'b1);
    cyc(4);
    chk("up 00:59", 32'(a_dig), 32'h0059);
    cyc(4);
    chk("up 01:00", 32'(a_dig), 32'h0100);
    pulse_stop();
    do_load(8'h99, 8'h58);
    pulse_start(1'b1);
    cyc(4);
    chk("up terminal", 32'(a_dig), 32'h9959);
    chk("up done", 32'(a_done), 32'h1);
    chk("up alarm", 32'(a_alarm), 32'h1);
    cyc(4);
    chk("up wrap 00:00", 32'(b_dig), 32'h0000);

    // Reset mid-run
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("reset run digits", 32'(b_dig), 32'h0000);
    chk("reset running", 32'(b_run), 32'h0);
    chk("reset alarm", 32'(a_alarm), 32'h0);

    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      load  = ($urandom_range(0, 24) == 0);
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      ack   = ($urandom_range(0, 9) == 0);
      up    = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       begin pmin = 8'h00; psec = 8'($urandom_range(0, 5)); end
        1:       begin pmin = 8'h99; psec = {4'h5, 4'($urandom_range(4, 9))}; end
        default: begin pmin = rnd_bcd(9); psec = rnd_bcd(5); end
      endcase
      cyc(1);
    end
    reset = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; ack = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
